cmat_bank_buffer: RTL and testbench

- Parametrised complex-matrix buffer holding N_MAT square matrices of MATRIX_DIM x MATRIX_DIM complex words, with real and imaginary planes stored in parallel.
- Loaded through a valid/ready stream with an internal auto-incrementing address. Each beat carries one complex element.
- Reads return a full row or a full column in one access. Column mode feeds the B operand of the matrix multiplier directly.
- Sits between the CSV/host loader and the multiply datapath.

---
 rtl/cmat_bank_buffer.sv | 160 ++++++++++++++++
 tb/tb_cmat_bank_buffer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmat_bank_buffer.sv
// Complex-matrix bank buffer.
// Holds N_MAT square matrices of MATRIX_DIM x MATRIX_DIM complex words with the
// real and imaginary planes stored side by side. A bank is filled by a
// row-major load stream. It is read one full row or one full column per access,
// with a registered result one cycle after the request.
//
// Load handshake: a beat transfers on a rising edge where ld_valid and ld_ready
// are both high. ld_ready depends only on the FSM state and never on ld_valid,
// so the producer may hold ld_valid low for any number of cycles. While
// ld_valid is low the write position stays where it is.
module cmat_bank_buffer #(
  parameter int WORD_LEN   = 32,
  parameter int MATRIX_DIM = 8,
  parameter int N_MAT      = 2,
  parameter int MSEL_W     = (N_MAT > 1) ? $clog2(N_MAT) : 1,
  parameter int IDX_W      = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_start,
  input  logic [MSEL_W-1:0]            ld_mat,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [WORD_LEN-1:0]          ld_real,
  input  logic [WORD_LEN-1:0]          ld_imag,
  output logic                         ld_busy,
  output logic [N_MAT-1:0]             loaded,
  input  logic                         rd_en,
  input  logic [MSEL_W-1:0]            rd_mat,
  input  logic                         rd_col,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic [WORD_LEN*MATRIX_DIM-1:0] rd_real,
  output logic [WORD_LEN*MATRIX_DIM-1:0] rd_imag
);

  localparam int VEC_W = WORD_LEN * MATRIX_DIM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_DIM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [MSEL_W-1:0] ld_bank;
  logic [IDX_W-1:0]  wr_row;
  logic [IDX_W-1:0]  wr_col;

  // Storage is deliberately left without reset; the loaded flags gate every read.
  logic [WORD_LEN-1:0] mem_re [N_MAT][MATRIX_DIM][MATRIX_DIM];
  logic [WORD_LEN-1:0] mem_im [N_MAT][MATRIX_DIM][MATRIX_DIM];

  logic start_ok;
  logic beat;
  logic last_beat;
  logic rd_mat_ok;
  logic rd_idx_ok;
  logic rd_ok;

  logic [VEC_W-1:0] vec_re;
  logic [VEC_W-1:0] vec_im;

  // Out-of-range bank numbers are dropped rather than aliased onto a real bank.
  assign start_ok  = ld_start && (32'(ld_mat) < 32'(N_MAT));
  assign beat      = ld_valid && ld_ready;
  assign last_beat = beat && (wr_row == LAST_IDX) && (wr_col == LAST_IDX);

  // Next-state and load-side handshake outputs.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, write position and per-bank completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ld_bank <= '0;
      wr_row  <= '0;
      wr_col  <= '0;
      loaded  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start_ok) begin
        ld_bank         <= ld_mat;
        wr_row          <= '0;
        wr_col          <= '0;
        loaded[ld_mat]  <= 1'b0;
      end else if (beat) begin
        if (wr_col == LAST_IDX) begin
          wr_col <= '0;
          wr_row <= (wr_row == LAST_IDX) ? '0 : wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
        if (last_beat) begin
          loaded[ld_bank] <= 1'b1;
        end
      end
    end
  end

  // Element write for each accepted beat, row-major within the bank being loaded.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem_re[ld_bank][wr_row][wr_col] <= ld_real;
      mem_im[ld_bank][wr_row][wr_col] <= ld_imag;
    end
  end

  // Lane k carries element (rd_idx, k) for a row read or (k, rd_idx) for a column read.
  for (genvar k = 0; k < MATRIX_DIM; k++) begin : g_lane
    assign vec_re[k*WORD_LEN +: WORD_LEN] = rd_col ? mem_re[rd_mat][k][rd_idx]
                                                   : mem_re[rd_mat][rd_idx][k];
    assign vec_im[k*WORD_LEN +: WORD_LEN] = rd_col ? mem_im[rd_mat][k][rd_idx]
                                                   : mem_im[rd_mat][rd_idx][k];
  end

  // A read is served only from a complete bank that is not being rewritten.
  assign rd_mat_ok = 32'(rd_mat) < 32'(N_MAT);
  assign rd_idx_ok = 32'(rd_idx) < 32'(MATRIX_DIM);
  assign rd_ok     = rd_en && rd_mat_ok && rd_idx_ok && loaded[rd_mat] &&
                     !((state == LOAD) && (ld_bank == rd_mat));

  // Registered read port; the data holds its last value when a read is refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_real  <= '0;
      rd_imag  <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_real <= vec_re;
        rd_imag <= vec_im;
      end
    end
  end

endmodule

// File: tb/tb_cmat_bank_buffer.sv
// Testbench for cmat_bank_buffer: random and directed load/read traffic checked
// against a flat array model of the banks.
module tb_cmat_bank_buffer;

  localparam int W   = 32;
  localparam int DIM = 8;
  localparam int NM  = 2;
  localparam int NE  = DIM * DIM;
  localparam int VW  = W * DIM;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ld_start = 1'b0;
  logic [0:0]    ld_mat   = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [W-1:0]  ld_real  = '0;
  logic [W-1:0]  ld_imag  = '0;
  logic          ld_busy;
  logic [NM-1:0] loaded;
  logic          rd_en    = 1'b0;
  logic [0:0]    rd_mat   = '0;
  logic          rd_col   = 1'b0;
  logic [2:0]    rd_idx   = '0;
  logic          rd_valid;
  logic [VW-1:0] rd_real;
  logic [VW-1:0] rd_imag;

  cmat_bank_buffer #(
    .WORD_LEN(W), .MATRIX_DIM(DIM), .N_MAT(NM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_mat(ld_mat), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_real(ld_real), .ld_imag(ld_imag), .ld_busy(ld_busy), .loaded(loaded),
    .rd_en(rd_en), .rd_mat(rd_mat), .rd_col(rd_col), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_real(rd_real), .rd_imag(rd_imag)
  );

  int errors = 0;
  int checks = 0;

  // reference model: each bank is a flat row-major element list
  logic [W-1:0]  m_re [NM][NE];
  logic [W-1:0]  m_im [NM][NE];
  logic [NM-1:0] m_loaded;
  bit            m_loading;
  int            m_bank;
  int            m_cnt;
  logic          exp_valid;
  logic [VW-1:0] exp_re;
  logic [VW-1:0] exp_im;

  logic [W-1:0]  src_re [NE];
  logic [W-1:0]  src_im [NE];

  task automatic model_reset();
    m_loaded  = '0;
    m_loading = 0;
    m_bank    = 0;
    m_cnt     = 0;
    exp_valid = 1'b0;
    exp_re    = '0;
    exp_im    = '0;
  endtask

  // Advance one clock: resolve the pending read and load beat in the model, then step the DUT.
  task automatic tick();
    bit ok;
    int e;
    if (!rst_n) begin
      model_reset();
      @(posedge clk); #1;
      return;
    end
    ok = rd_en && (int'(rd_mat) < NM) && (int'(rd_idx) < DIM) && m_loaded[rd_mat] &&
         !(m_loading && (m_bank == int'(rd_mat)));
    exp_valid = ok;
    if (ok) begin
      for (int k = 0; k < DIM; k++) begin
        e = rd_col ? (k * DIM + int'(rd_idx)) : (int'(rd_idx) * DIM + k);
        exp_re[k*W +: W] = m_re[rd_mat][e];
        exp_im[k*W +: W] = m_im[rd_mat][e];
      end
    end
    if (m_loading) begin
      if (ld_valid) begin
        m_re[m_bank][m_cnt] = ld_real;
        m_im[m_bank][m_cnt] = ld_imag;
        m_cnt++;
        if (m_cnt == NE) begin
          m_loaded[m_bank] = 1'b1;
          m_loading = 0;
        end
      end
    end else if (ld_start && (int'(ld_mat) < NM)) begin
      m_loading        = 1;
      m_bank           = int'(ld_mat);
      m_cnt            = 0;
      m_loaded[ld_mat] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_random_src();
    for (int i = 0; i < NE; i++) begin
      src_re[i] = $urandom;
      src_im[i] = $urandom;
    end
  endtask

  task automatic rand_read();
    rd_en  = ($urandom_range(0, 3) != 0);
    rd_mat = 1'($urandom_range(0, 1));
    rd_col = 1'($urandom_range(0, 1));
    rd_idx = 3'($urandom_range(0, DIM - 1));
  endtask

  // Full load of one bank from src_*, reads idle.
  task automatic drive_load(input int bank);
    int guard;
    guard    = 0;
    rd_en    = 1'b0;
    ld_start = 1'b1;
    ld_mat   = 1'(bank);
    tick();
    ld_start = 1'b0;
    while (m_loading && guard < 400) begin
      ld_valid = 1'b1;
      ld_real  = src_re[m_cnt];
      ld_imag  = src_im[m_cnt];
      tick();
      guard++;
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (ld_ready !== 1'b0 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ld: ld_ready=%b ld_busy=%b expected 0 0", ld_ready, ld_busy);
    end
    checks++;
    if (loaded !== 2'b00) begin
      errors++;
      $display("FAIL reset_loaded: loaded=%b expected 00", loaded);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_real !== '0 || rd_imag !== '0) begin
      errors++;
      $display("FAIL reset_rd: rd_valid=%b rd_real=%h rd_imag=%h expected all zero", rd_valid, rd_real, rd_imag);
    end
    rst_n = 1'b1;
    ld_valid = 1'b1;
    tick();
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: ld_ready=%b expected 0", ld_ready);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_row_read();
    for (int i = 0; i < NE; i++) begin
      src_re[i] = W'(i);
      src_im[i] = W'(32'h100 + i);
    end
    drive_load(0);
    checks++;
    if (loaded !== 2'b01) begin
      errors++;
      $display("FAIL load0_done: loaded=%b expected 01", loaded);
    end
    rd_en = 1'b1; rd_mat = 1'b0; rd_col = 1'b0; rd_idx = 3'd2;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_real !== exp_re || rd_imag !== exp_im) begin
      errors++;
      $display("FAIL row2: v=%b re=%h im=%h expected v=1 re=%h im=%h", rd_valid, rd_real, rd_imag, exp_re, exp_im);
    end
    checks++;
    if (rd_real[0 +: W] !== 32'h10 || rd_real[7*W +: W] !== 32'h17 || rd_imag[0 +: W] !== 32'h110) begin
      errors++;
      $display("FAIL row2_lanes: re0=%h re7=%h im0=%h expected 10 17 110",
               rd_real[0 +: W], rd_real[7*W +: W], rd_imag[0 +: W]);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_real !== exp_re) begin
      errors++;
      $display("FAIL row2_hold: v=%b re=%h expected v=0 re=%h", rd_valid, rd_real, exp_re);
    end
  endtask

  task automatic test_col_read();
    rd_en = 1'b1; rd_mat = 1'b0; rd_col = 1'b1; rd_idx = 3'd3;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_real !== exp_re || rd_imag !== exp_im) begin
      errors++;
      $display("FAIL col3: v=%b re=%h im=%h expected v=1 re=%h im=%h", rd_valid, rd_real, rd_imag, exp_re, exp_im);
    end
    checks++;
    if (rd_real[0 +: W] !== 32'h03 || rd_real[W +: W] !== 32'h0B ||
        rd_real[7*W +: W] !== 32'h3B || rd_imag[7*W +: W] !== 32'h13B) begin
      errors++;
      $display("FAIL col3_lanes: re0=%h re1=%h re7=%h im7=%h expected 03 0b 3b 13b",
               rd_real[0 +: W], rd_real[W +: W], rd_real[7*W +: W], rd_imag[7*W +: W]);
    end
  endtask

  task automatic test_unloaded_read();
    rd_en = 1'b1; rd_mat = 1'b1; rd_col = 1'b0; rd_idx = 3'd0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_real !== exp_re || rd_imag !== exp_im) begin
      errors++;
      $display("FAIL unloaded_read: v=%b re=%h expected v=0 held re=%h", rd_valid, rd_real, exp_re);
    end
  endtask

  task automatic test_gapped_load();
    int obs_beats;
    int guard;
    bit ph;
    obs_beats = 0;
    guard     = 0;
    ph        = 1;
    fill_random_src();
    ld_start = 1'b1; ld_mat = 1'b1;
    rand_read();
    tick();
    ld_start = 1'b0;
    while (m_loading && guard < 400) begin
      ld_valid = ph;
      ph = ~ph;
      ld_real = src_re[m_cnt];
      ld_imag = src_im[m_cnt];
      rand_read();
      if (ld_valid && ld_ready) obs_beats++;
      tick();
      guard++;
      checks++;
      if (rd_valid !== exp_valid || rd_real !== exp_re || rd_imag !== exp_im || ld_ready !== 1'(m_loading)) begin
        errors++;
        $display("FAIL gap_cycle%0d: v=%b rdy=%b re=%h expected v=%b rdy=%b re=%h",
                 guard, rd_valid, ld_ready, rd_real, exp_valid, m_loading, exp_re);
      end
    end
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    checks++;
    if (obs_beats != NE) begin
      errors++;
      $display("FAIL gap_beats: accepted=%0d expected %0d", obs_beats, NE);
    end
    checks++;
    if (loaded !== 2'b11) begin
      errors++;
      $display("FAIL gap_loaded: loaded=%b expected 11", loaded);
    end
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    checks++;
    if (ld_ready !== 1'b0 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_idle: ld_ready=%b ld_busy=%b expected 0 0", ld_ready, ld_busy);
    end
  endtask

  task automatic test_random_reads();
    for (int n = 0; n < 40; n++) begin
      rand_read();
      tick();
      checks++;
      if (rd_valid !== exp_valid || rd_real !== exp_re || rd_imag !== exp_im) begin
        errors++;
        $display("FAIL rand_read%0d: v=%b re=%h im=%h expected v=%b re=%h im=%h",
                 n, rd_valid, rd_real, rd_imag, exp_valid, exp_re, exp_im);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reload();
    int guard;
    guard = 0;
    fill_random_src();
    ld_start = 1'b1; ld_mat = 1'b0;
    rd_en = 1'b0;
    tick();
    ld_start = 1'b0;
    checks++;
    if (loaded !== 2'b10) begin
      errors++;
      $display("FAIL reload_clear: loaded=%b expected 10", loaded);
    end
    while (m_loading && guard < 400) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_real  = src_re[m_cnt];
      ld_imag  = src_im[m_cnt];
      rd_en = 1'b1; rd_mat = 1'b0;
      rd_col = 1'($urandom_range(0, 1));
      rd_idx = 3'($urandom_range(0, DIM - 1));
      tick();
      guard++;
      checks++;
      if (rd_valid !== exp_valid || rd_real !== exp_re || rd_imag !== exp_im) begin
        errors++;
        $display("FAIL reload_cycle%0d: v=%b re=%h expected v=%b re=%h", guard, rd_valid, rd_real, exp_valid, exp_re);
      end
    end
    ld_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reload_last_beat_read: v=%b expected 0", rd_valid);
    end
    rd_col = 1'b0; rd_idx = 3'd5;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_real !== exp_re || rd_imag !== exp_im ||
        rd_real[0 +: W] !== src_re[40]) begin
      errors++;
      $display("FAIL reload_new_data: v=%b re=%h expected v=1 re=%h", rd_valid, rd_real, exp_re);
    end
  endtask

  task automatic test_reset_mid_load();
    fill_random_src();
    ld_start = 1'b1; ld_mat = 1'b1;
    tick();
    ld_start = 1'b0;
    while (m_cnt < 30) begin
      ld_valid = 1'b1;
      ld_real  = src_re[m_cnt];
      ld_imag  = src_im[m_cnt];
      rd_en = 1'b1; rd_mat = 1'b0; rd_col = 1'b0; rd_idx = 3'(m_cnt % DIM);
      tick();
    end
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || ld_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: v=%b busy=%b expected 1 1", rd_valid, ld_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (loaded !== 2'b00 || ld_ready !== 1'b0 || rd_valid !== 1'b0 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: loaded=%b rdy=%b v=%b busy=%b expected 00 0 0 0", loaded, ld_ready, rd_valid, ld_busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fill_random_src();
    drive_load(1);
    checks++;
    if (loaded !== 2'b10) begin
      errors++;
      $display("FAIL after_reset_load: loaded=%b expected 10", loaded);
    end
    for (int n = 0; n < 2 * DIM; n++) begin
      rd_en = 1'b1; rd_mat = 1'b1;
      rd_col = 1'(n / DIM);
      rd_idx = 3'(n % DIM);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_real !== exp_re || rd_imag !== exp_im) begin
        errors++;
        $display("FAIL after_reset_read%0d: v=%b re=%h expected v=1 re=%h", n, rd_valid, rd_real, exp_re);
      end
    end
    rd_mat = 1'b0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_bank0: v=%b expected 0", rd_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_row_read();
    test_col_read();
    test_unloaded_read();
    test_gapped_load();
    test_random_reads();
    test_reload();
    test_random_reads();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
